// File: rtl/div_mon_pkg.sv
// div_mon_pkg: shared types and constants for the divided-clock monitor.
// State encoding, default counter width and the width of the in-range run counter.
package div_mon_pkg;

  // Default width of the period / high-time counters.
  localparam int DIV_MON_CNT_W = 16;

  // Width of the consecutive in-range counter; LOCK_CNT is limited to 1..15.
  localparam int DIV_MON_GOOD_W = 4;

  // Monitor states.
  typedef enum logic [1:0] {
    DM_IDLE  = 2'd0,
    DM_MEAS  = 2'd1,
    DM_LOCK  = 2'd2,
    DM_FAULT = 2'd3
  } div_mon_state_e;

endpackage

// File: rtl/div_clk_monitor_if.sv
// div_clk_monitor_if: bundle of the monitor's input and result signals.
// Inputs: i_mon is the divided clock under observation, i_clr a level-sampled
// synchronous clear. Outputs are single-cycle pulses (o_tick, o_period_vld) or
// levels (o_locked, o_err) all launched from registers; no handshake back-pressure
// exists: every pulse is valid for exactly one clk cycle and is never stalled.
// o_dbg_state exposes the FSM state (div_mon_state_e encoding).
interface div_clk_monitor_if
  import div_mon_pkg::*;
#(
  parameter int CNT_W = DIV_MON_CNT_W
);
  logic             i_mon;
  logic             i_clr;
  logic             o_tick;
  logic [CNT_W-1:0] o_period;
  logic             o_period_vld;
  logic [CNT_W-1:0] o_high;
  logic             o_locked;
  logic             o_err;
  logic [1:0]       o_dbg_state;

  modport master (
    output i_mon, i_clr,
    input  o_tick, o_period, o_period_vld, o_high, o_locked, o_err, o_dbg_state
  );

  modport slave (
    input  i_mon, i_clr,
    output o_tick, o_period, o_period_vld, o_high, o_locked, o_err, o_dbg_state
  );
endinterface

// File: rtl/div_mon_edge.sv
// div_mon_edge: samples the monitored clock and produces registered level,
// rise and fall flags, all aligned to the same sample.
// Build option: DIV_MON_SYNC_EN inserts a 2-flop synchronizer in front of the
// sampler (one extra cycle of latency); without it a single sampling register
// is used, suitable for a same-domain source.
module div_mon_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_mon,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic w_samp;
  logic w_samp_vld;
  logic r_prev;
  logic r_prev_vld;

`ifdef DIV_MON_SYNC_EN
  logic [1:0] r_sync;
  logic [1:0] r_sync_vld;

  // Two-stage synchronizer; the valid bits track which stages hold real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b00;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync     <= {r_sync[0], i_mon};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_samp     = r_sync[1];
  assign w_samp_vld = r_sync_vld[1];
`else
  logic r_samp;
  logic r_samp_vld;

  // Single sampling register for a same-domain source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp     <= 1'b0;
      r_samp_vld <= 1'b0;
    end else begin
      r_samp     <= i_mon;
      r_samp_vld <= 1'b1;
    end
  end

  assign w_samp     = r_samp;
  assign w_samp_vld = r_samp_vld;
`endif

  // Edge detection: an edge needs a genuine previous sample, so the reset value
  // of the sampler can never fake a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
      o_lvl      <= 1'b0;
      o_rise     <= 1'b0;
      o_fall     <= 1'b0;
    end else begin
      r_prev     <= w_samp;
      r_prev_vld <= w_samp_vld;
      o_lvl      <= w_samp & w_samp_vld;
      o_rise     <= w_samp & ~r_prev & r_prev_vld;
      o_fall     <= ~w_samp & r_prev & r_prev_vld;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of a divided clock in clk
// cycles, declares lock after LOCK_CNT consecutive in-range periods and flags a
// sticky error when a locked signal drifts out of range or stops toggling.
// Build option: DIV_MON_SYNC_EN (passed to div_mon_edge) adds an input
// synchronizer; measured values are identical in both builds.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W    = DIV_MON_CNT_W,
  parameter int EXP_MIN  = 59,
  parameter int EXP_MAX  = 63,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input logic              clk,
  input logic              rst,
  div_clk_monitor_if.slave bus
);

  localparam int GOOD_W = DIV_MON_GOOD_W;

  localparam logic [1:0] ST_IDLE  = DM_IDLE;
  localparam logic [1:0] ST_MEAS  = DM_MEAS;
  localparam logic [1:0] ST_LOCK  = DM_LOCK;
  localparam logic [1:0] ST_FAULT = DM_FAULT;

  localparam logic [CNT_W-1:0]  C_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_TMO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  C_EXP_MIN  = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  C_EXP_MAX  = CNT_W'(EXP_MAX);
  localparam logic [GOOD_W-1:0] C_LOCK_CNT = GOOD_W'(LOCK_CNT);

  logic              w_lvl;
  logic              w_rise;
  logic              w_fall;
  logic              w_clr;
  logic [CNT_W-1:0]  w_period;
  logic              w_in_range;
  logic              w_timeout;
  logic [GOOD_W-1:0] w_good_inc;
  logic [1:0]        w_state_nxt;
  logic [GOOD_W-1:0] w_good_nxt;

  logic [1:0]        r_state;
  logic [GOOD_W-1:0] r_good;
  logic [CNT_W-1:0]  r_pcnt;
  logic [CNT_W-1:0]  r_hcnt;
  logic              r_tick;
  logic [CNT_W-1:0]  r_period;
  logic              r_period_vld;
  logic [CNT_W-1:0]  r_high;
  logic              r_locked;
  logic              r_err;

  div_mon_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_mon  (bus.i_mon),
    .o_lvl  (w_lvl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_clr      = bus.i_clr;
  assign w_period   = r_pcnt + CNT_W'(1);
  // A saturated counter means the real period is unknown, so it never qualifies.
  assign w_in_range = (r_pcnt != C_TIMEOUT) && (w_period >= C_EXP_MIN) &&
                      (w_period <= C_EXP_MAX);
  // The counter is about to reach TIMEOUT on this edge without a new rise.
  assign w_timeout  = !w_rise && (r_pcnt == C_TMO_M1);
  assign w_good_inc = r_good + GOOD_W'(1);

  // Next-state and in-range run counter; clear overrides everything, including a rise.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (w_clr) begin
      w_state_nxt = ST_IDLE;
      w_good_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_MEAS;
            w_good_nxt  = '0;
          end
        end
        ST_MEAS: begin
          if (w_rise) begin
            if (w_in_range) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == C_LOCK_CNT) w_state_nxt = ST_LOCK;
            end else begin
              w_good_nxt = '0;
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_good_nxt  = '0;
          end
        end
        ST_LOCK: begin
          if (w_rise && !w_in_range) w_state_nxt = ST_FAULT;
          else if (w_timeout)        w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_FAULT;
        end
      endcase
    end
  end

  // State, run counter and status flags, registered together so they line up with o_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_locked <= (w_state_nxt == ST_LOCK);
      r_err    <= (w_state_nxt == ST_FAULT);
    end
  end

  // Period counter: restarts at each rise, saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_clr || w_rise) begin
      r_pcnt <= '0;
    end else if (r_pcnt != C_TIMEOUT) begin
      r_pcnt <= r_pcnt + CNT_W'(1);
    end
  end

  // High-time counter and its publication at the falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_high <= '0;
    end else begin
      if (w_rise) r_hcnt <= '0;
      else if (w_lvl && (r_hcnt != '1)) r_hcnt <= r_hcnt + CNT_W'(1);
      if (w_fall) r_high <= r_hcnt + CNT_W'(1);
    end
  end

  // Tick and period publication; the first rise after IDLE has no reference edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick       <= 1'b0;
      r_period_vld <= 1'b0;
      r_period     <= '0;
    end else begin
      r_tick       <= w_rise && !w_clr;
      r_period_vld <= w_rise && !w_clr && (r_state != ST_IDLE);
      if (w_rise && !w_clr && (r_state != ST_IDLE)) r_period <= w_period;
    end
  end

  assign bus.o_tick       = r_tick;
  assign bus.o_period     = r_period;
  assign bus.o_period_vld = r_period_vld;
  assign bus.o_high       = r_high;
  assign bus.o_locked     = r_locked;
  assign bus.o_err        = r_err;
  assign bus.o_dbg_state  = r_state;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: directed test of div_clk_monitor with immediate assertions.
// Build option: DIV_MON_SYNC_EN changes the expected tick latency from 2 to 3.
module tb_div_clk_monitor;
  import div_mon_pkg::*;

`ifdef DIV_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int TIMEOUT = 255;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  div_clk_monitor_if #(.CNT_W(16)) bus ();

  div_clk_monitor #(
    .CNT_W(16), .EXP_MIN(59), .EXP_MAX(63), .LOCK_CNT(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_tick, n_vld, lock_at, err_seen, err_at, last_tick_at;
  int p_min, p_max, last_period;
  logic vld_err, vld_locked;
  int s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_tick = 0; n_vld = 0; lock_at = 0; err_seen = 0; err_at = 0;
    last_tick_at = 0; p_min = 99999; p_max = 0; last_period = 0;
    vld_err = 1'b0; vld_locked = 1'b0;
  endtask

  // One clock: wait for the edge, then observe 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.o_tick) begin
      n_tick++;
      last_tick_at = cyc;
    end
    if (bus.o_period_vld) begin
      n_vld++;
      last_period = int'(bus.o_period);
      vld_err     = bus.o_err;
      vld_locked  = bus.o_locked;
      if (last_period < p_min) p_min = last_period;
      if (last_period > p_max) p_max = last_period;
    end
    if (bus.o_locked && lock_at == 0) lock_at = n_tick;
    if (bus.o_err && err_seen == 0) begin
      err_seen = 1;
      err_at   = cyc;
    end
  endtask

  task automatic run_period(input int hi, input int lo);
    bus.i_mon = 1'b1;
    repeat (hi) step();
    bus.i_mon = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_mon = 1'b0;
    bus.i_clr = 1'b0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", bus.o_tick, 0);
    chk("rst_vld", bus.o_period_vld, 0);
    chk("rst_period", bus.o_period, 0);
    chk("rst_high", bus.o_high, 0);
    chk("rst_locked", bus.o_locked, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_state", bus.o_dbg_state, DM_IDLE);
    rst = 1'b0;
    repeat (5) step();

    // First rise: tick latency and no period on the first rise.
    bus.i_mon = 1'b1;
    s = 0;
    while (!bus.o_tick && s < 10) begin
      step();
      s++;
    end
    chk("tick_latency", s - 1, LAT);
    chk("first_rise_no_vld", n_vld, 0);
    repeat (30 - s) step();
    bus.i_mon = 1'b0;
    repeat (31) step();

    // Four more 61-cycle periods, 30 high: lock at the 5th rise.
    clr_stats();
    repeat (4) run_period(30, 31);
    chk("lock_ticks", n_tick, 4);
    chk("lock_vld", n_vld, 4);
    chk("lock_pmin", p_min, 61);
    chk("lock_pmax", p_max, 61);
    chk("lock_high", bus.o_high, 30);
    chk("lock_at_tick", lock_at, 4);
    chk("lock_locked", bus.o_locked, 1);
    chk("lock_no_err", err_seen, 0);
    chk("lock_state", bus.o_dbg_state, DM_LOCK);

    // One stretched period of 70 while locked.
    clr_stats();
    run_period(30, 40);
    run_period(30, 31);
    chk("stretch_vld", n_vld, 2);
    chk("stretch_period", last_period, 70);
    chk("stretch_err_same", vld_err, 1);
    chk("stretch_unlock_same", vld_locked, 0);
    chk("stretch_state", bus.o_dbg_state, DM_FAULT);

    // Clear, then relock after 5 good rises.
    bus.i_clr = 1'b1;
    step();
    bus.i_clr = 1'b0;
    chk("clr_state", bus.o_dbg_state, DM_IDLE);
    chk("clr_err", bus.o_err, 0);
    chk("clr_locked", bus.o_locked, 0);
    clr_stats();
    repeat (5) run_period(30, 31);
    chk("relock_vld", n_vld, 4);
    chk("relock_at", lock_at, 5);
    chk("relock_locked", bus.o_locked, 1);

    // Hold i_mon low: loss after exactly TIMEOUT cycles from the last tick.
    for (int i = 0; i < 300 && err_seen == 0; i++) step();
    chk("tmo_err_seen", err_seen, 1);
    chk("tmo_gap", err_at - last_tick_at, TIMEOUT);
    chk("tmo_locked", bus.o_locked, 0);
    chk("tmo_state", bus.o_dbg_state, DM_FAULT);

    // Clear, then alternate 61 / 50: never locks, no error.
    bus.i_clr = 1'b1;
    step();
    bus.i_clr = 1'b0;
    clr_stats();
    repeat (3) begin
      run_period(30, 31);
      run_period(25, 25);
    end
    run_period(30, 31);
    chk("alt_ticks", n_tick, 7);
    chk("alt_vld", n_vld, 6);
    chk("alt_no_lock", lock_at, 0);
    chk("alt_no_err", err_seen, 0);
    chk("alt_pmin", p_min, 50);
    chk("alt_pmax", p_max, 61);
    chk("alt_last", last_period, 50);

    // Clear on the very cycle a rise is detected: rise discarded.
    clr_stats();
    bus.i_mon = 1'b1;
    repeat (LAT) step();
    bus.i_clr = 1'b1;
    step();
    bus.i_clr = 1'b0;
    chk("clrrise_vld", bus.o_period_vld, 0);
    chk("clrrise_state", bus.o_dbg_state, DM_IDLE);
    repeat (30 - LAT - 1) step();
    bus.i_mon = 1'b0;
    repeat (31) step();
    clr_stats();
    run_period(30, 31);
    chk("clrrise_next_first_tick", n_tick, 1);
    chk("clrrise_next_first_vld", n_vld, 0);
    run_period(30, 31);
    chk("clrrise_second_vld", n_vld, 1);
    chk("clrrise_second_period", last_period, 61);
    chk("clrrise_state_meas", bus.o_dbg_state, DM_MEAS);

    // Lock again, then asynchronous reset in the middle of a high phase.
    repeat (3) run_period(30, 31);
    chk("prereset_locked", bus.o_locked, 1);
    bus.i_mon = 1'b1;
    repeat (10) step();
    #5;
    rst = 1'b1;
    #1;
    chk("arst_tick", bus.o_tick, 0);
    chk("arst_vld", bus.o_period_vld, 0);
    chk("arst_period", bus.o_period, 0);
    chk("arst_high", bus.o_high, 0);
    chk("arst_locked", bus.o_locked, 0);
    chk("arst_err", bus.o_err, 0);
    chk("arst_state", bus.o_dbg_state, DM_IDLE);
    #40;
    rst = 1'b0;
    #40;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
